// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory bus between instruction fetch and data access,
//            generating byte strobes and reporting misaligned/timeout faults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // instruction fetch port
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_done,
    output logic [31:0]       o_if_rdata,
    output logic              o_if_stall,
    // data access port
    input  logic              i_mem_req,
    input  logic              i_mem_write,
    input  logic [1:0]        i_mem_size,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [31:0]       i_mem_wdata,
    output logic              o_mem_done,
    output logic [31:0]       o_mem_rdata,
    output logic              o_mem_stall,
    // fault reporting
    output logic              o_fault,
    output logic [1:0]        o_fault_cause,
    // memory bus
    output logic              o_bus_req,
    output logic              o_bus_write,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [3:0]        o_bus_wstrb,
    output logic [31:0]       o_bus_wdata,
    input  logic              i_bus_ready,
    input  logic [31:0]       i_bus_rdata
);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_if_busy  = 2'd1;
    localparam logic [1:0] c_st_mem_busy = 2'd2;
    localparam logic [1:0] c_st_resp     = 2'd3;

    localparam logic [1:0] c_cause_none     = 2'b00;
    localparam logic [1:0] c_cause_misalign = 2'b01;
    localparam logic [1:0] c_cause_timeout  = 2'b10;

    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;

    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);

    // registered state and outputs
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_if_done;
    logic              r_mem_done;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_mem_rdata;
    logic              r_fault;
    logic [1:0]        r_cause;
    logic              r_bus_req;
    logic              r_bus_write;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [3:0]        r_bus_wstrb;
    logic [31:0]       r_bus_wdata;

    // next-state values
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_if_done_nxt;
    logic              w_mem_done_nxt;
    logic [31:0]       w_if_rdata_nxt;
    logic [31:0]       w_mem_rdata_nxt;
    logic              w_fault_nxt;
    logic [1:0]        w_cause_nxt;
    logic              w_bus_req_nxt;
    logic              w_bus_write_nxt;
    logic [ADDR_W-1:0] w_bus_addr_nxt;
    logic [3:0]        w_bus_wstrb_nxt;
    logic [31:0]       w_bus_wdata_nxt;

    // request decode
    logic              w_mem_misaligned;
    logic [3:0]        w_mem_strb;
    logic [31:0]       w_mem_lanes;
    logic [ADDR_W-1:0] w_mem_addr_word;
    logic [ADDR_W-1:0] w_if_addr_word;
    logic              w_unused_if_lsb;

    assign w_mem_addr_word = {i_mem_addr[ADDR_W-1:2], 2'b00};
    assign w_if_addr_word  = {i_if_addr[ADDR_W-1:2], 2'b00};
    assign w_unused_if_lsb = ^i_if_addr[1:0];

    assign w_mem_misaligned = ((i_mem_size == c_size_half) && i_mem_addr[0])
                           || ((i_mem_size == c_size_word) && (i_mem_addr[1:0] != 2'b00))
                           || (i_mem_size == 2'b11);

    // Store data is replicated across every lane so the slave can pick any
    // enabled byte without knowing the access size.
    always_comb begin
        w_mem_strb  = 4'b0000;
        w_mem_lanes = i_mem_wdata;
        case (i_mem_size)
            c_size_byte: begin
                w_mem_strb  = 4'b0001 << i_mem_addr[1:0];
                w_mem_lanes = {4{i_mem_wdata[7:0]}};
            end
            c_size_half: begin
                w_mem_strb  = i_mem_addr[1] ? 4'b1100 : 4'b0011;
                w_mem_lanes = {2{i_mem_wdata[15:0]}};
            end
            c_size_word: begin
                w_mem_strb  = 4'b1111;
                w_mem_lanes = i_mem_wdata;
            end
            default: begin
                w_mem_strb  = 4'b0000;
                w_mem_lanes = i_mem_wdata;
            end
        endcase
        if (!i_mem_write) begin
            w_mem_strb = 4'b0000;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_if_done_nxt   = 1'b0;
        w_mem_done_nxt  = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_mem_rdata_nxt = r_mem_rdata;
        w_fault_nxt     = 1'b0;
        w_cause_nxt     = c_cause_none;
        w_bus_req_nxt   = r_bus_req;
        w_bus_write_nxt = r_bus_write;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wstrb_nxt = r_bus_wstrb;
        w_bus_wdata_nxt = r_bus_wdata;

        case (r_state)
            c_st_idle: begin
                // Data side wins; a misaligned access never reaches the bus.
                if (i_mem_req && w_mem_misaligned) begin
                    w_state_nxt    = c_st_resp;
                    w_mem_done_nxt = 1'b1;
                    w_fault_nxt    = 1'b1;
                    w_cause_nxt    = c_cause_misalign;
                end else if (i_mem_req) begin
                    w_state_nxt     = c_st_mem_busy;
                    w_cnt_nxt       = '0;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_write_nxt = i_mem_write;
                    w_bus_addr_nxt  = w_mem_addr_word;
                    w_bus_wstrb_nxt = w_mem_strb;
                    w_bus_wdata_nxt = w_mem_lanes;
                end else if (i_if_req) begin
                    w_state_nxt     = c_st_if_busy;
                    w_cnt_nxt       = '0;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_write_nxt = 1'b0;
                    w_bus_addr_nxt  = w_if_addr_word;
                    w_bus_wstrb_nxt = 4'b0000;
                    w_bus_wdata_nxt = 32'h0000_0000;
                end
            end

            c_st_if_busy, c_st_mem_busy: begin
                if (i_bus_ready) begin
                    w_state_nxt   = c_st_resp;
                    w_bus_req_nxt = 1'b0;
                    if (r_state == c_st_if_busy) begin
                        w_if_done_nxt  = 1'b1;
                        w_if_rdata_nxt = i_bus_rdata;
                    end else begin
                        w_mem_done_nxt  = 1'b1;
                        w_mem_rdata_nxt = i_bus_rdata;
                    end
                end else if (r_cnt == c_timeout_last) begin
                    w_state_nxt   = c_st_resp;
                    w_bus_req_nxt = 1'b0;
                    w_fault_nxt   = 1'b1;
                    w_cause_nxt   = c_cause_timeout;
                    if (r_state == c_st_if_busy) begin
                        w_if_done_nxt = 1'b1;
                    end else begin
                        w_mem_done_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            c_st_resp: begin
                // Done pulse is visible this cycle; grant again only from IDLE.
                w_state_nxt = c_st_idle;
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_rdata  <= 32'h0000_0000;
            r_mem_rdata <= 32'h0000_0000;
            r_fault     <= 1'b0;
            r_cause     <= c_cause_none;
            r_bus_req   <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wstrb <= 4'b0000;
            r_bus_wdata <= 32'h0000_0000;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_if_done   <= w_if_done_nxt;
            r_mem_done  <= w_mem_done_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_fault     <= w_fault_nxt;
            r_cause     <= w_cause_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_write <= w_bus_write_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wstrb <= w_bus_wstrb_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
        end
    end

    assign o_if_done     = r_if_done;
    assign o_if_rdata    = r_if_rdata;
    assign o_mem_done    = r_mem_done;
    assign o_mem_rdata   = r_mem_rdata;
    assign o_fault       = r_fault;
    assign o_fault_cause = r_cause;
    assign o_bus_req     = r_bus_req;
    assign o_bus_write   = r_bus_write;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_wstrb   = r_bus_wstrb;
    assign o_bus_wdata   = r_bus_wdata;

    // Stalls release in the same cycle the done pulse appears.
    assign o_if_stall  = i_if_req  & ~r_if_done;
    assign o_mem_stall = i_mem_req & ~r_mem_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter with a response
//            scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        mem_req;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        bus_req;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic        is_mem;
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    exp_t sb[$];

    logic [1:0]  mis_size [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] mis_addr [3] = '{32'h101, 32'h102, 32'h100};

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_if_req      (if_req),
        .i_if_addr     (if_addr),
        .o_if_done     (if_done),
        .o_if_rdata    (if_rdata),
        .o_if_stall    (if_stall),
        .i_mem_req     (mem_req),
        .i_mem_write   (mem_write),
        .i_mem_size    (mem_size),
        .i_mem_addr    (mem_addr),
        .i_mem_wdata   (mem_wdata),
        .o_mem_done    (mem_done),
        .o_mem_rdata   (mem_rdata),
        .o_mem_stall   (mem_stall),
        .o_fault       (fault),
        .o_fault_cause (fault_cause),
        .o_bus_req     (bus_req),
        .o_bus_write   (bus_write),
        .o_bus_addr    (bus_addr),
        .o_bus_wstrb   (bus_wstrb),
        .o_bus_wdata   (bus_wdata),
        .i_bus_ready   (bus_ready),
        .i_bus_rdata   (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // drive point just after the rising edge; sample point on the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic is_mem, input logic chk_rd, input logic [31:0] rd,
                            input logic f, input logic [1:0] c);
        exp_t e;
        e.is_mem    = is_mem;
        e.chk_rdata = chk_rd;
        e.rdata     = rd;
        e.fault     = f;
        e.cause     = c;
        sb.push_back(e);
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        chk({tag, ".sb_pending"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".if_done"},  32'(if_done),  32'(!e.is_mem));
            chk({tag, ".mem_done"}, 32'(mem_done), 32'(e.is_mem));
            chk({tag, ".fault"},    32'(fault),    32'(e.fault));
            chk({tag, ".cause"},    32'(fault_cause), 32'(e.cause));
            if (e.chk_rdata) begin
                chk({tag, ".rdata"}, e.is_mem ? mem_rdata : if_rdata, e.rdata);
            end
        end
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (if_done || mem_done) break;
            tick();
            mid();
        end
        chk({tag, ".done_seen"}, 32'(if_done | mem_done), 32'd1);
        if (if_done || mem_done) check_resp(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".bus_req"},   32'(bus_req),   32'd0);
        chk({tag, ".bus_write"}, 32'(bus_write), 32'd0);
        chk({tag, ".bus_addr"},  bus_addr,       32'd0);
        chk({tag, ".bus_wstrb"}, 32'(bus_wstrb), 32'd0);
        chk({tag, ".bus_wdata"}, bus_wdata,      32'd0);
        chk({tag, ".if_done"},   32'(if_done),   32'd0);
        chk({tag, ".mem_done"},  32'(mem_done),  32'd0);
        chk({tag, ".fault"},     32'(fault),     32'd0);
        chk({tag, ".cause"},     32'(fault_cause), 32'd0);
        chk({tag, ".if_rdata"},  if_rdata,       32'd0);
        chk({tag, ".mem_rdata"}, mem_rdata,      32'd0);
    endtask

    initial begin
        int n_busy;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;

        tick();
        tick();
        mid();
        check_all_zero("reset");
        chk("reset.if_stall",  32'(if_stall),  32'd0);
        chk("reset.mem_stall", 32'(mem_stall), 32'd0);
        tick();
        rst = 1'b0;
        mid();

        // single fetch
        tick(); if_req = 1'b1; if_addr = 32'h100; mid();
        chk("t1.c0.stall",   32'(if_stall), 32'd1);
        chk("t1.c0.bus_req", 32'(bus_req),  32'd0);
        tick(); bus_ready = 1'b1; bus_rdata = 32'h0000_0013;
        push_exp(1'b0, 1'b1, 32'h0000_0013, 1'b0, 2'b00); mid();
        chk("t1.c1.bus_req",  32'(bus_req),   32'd1);
        chk("t1.c1.addr",     bus_addr,       32'h100);
        chk("t1.c1.write",    32'(bus_write), 32'd0);
        chk("t1.c1.wstrb",    32'(bus_wstrb), 32'd0);
        chk("t1.c1.stall",    32'(if_stall),  32'd1);
        tick(); bus_ready = 1'b0; bus_rdata = 32'h0; mid();
        check_resp("t1.c2");
        chk("t1.c2.stall",   32'(if_stall), 32'd0);
        chk("t1.c2.bus_req", 32'(bus_req),  32'd0);
        tick(); if_req = 1'b0; mid();
        chk("t1.c3.if_done", 32'(if_done), 32'd0);

        // simultaneous requests: data side first
        tick();
        if_req = 1'b1; if_addr = 32'h400;
        mem_req = 1'b1; mem_write = 1'b1; mem_size = 2'b00; mem_addr = 32'h203; mem_wdata = 32'h0000_00AB;
        mid();
        chk("t2.c0.if_stall",  32'(if_stall),  32'd1);
        chk("t2.c0.mem_stall", 32'(mem_stall), 32'd1);
        tick(); bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        push_exp(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00); mid();
        chk("t2.c1.bus_req", 32'(bus_req),   32'd1);
        chk("t2.c1.write",   32'(bus_write), 32'd1);
        chk("t2.c1.addr",    bus_addr,       32'h200);
        chk("t2.c1.wstrb",   32'(bus_wstrb), 32'b1000);
        chk("t2.c1.wdata",   bus_wdata,      32'hABAB_ABAB);
        tick(); bus_ready = 1'b0; mid();
        check_resp("t2.mem");
        chk("t2.c2.bus_req",   32'(bus_req),   32'd0);
        chk("t2.c2.if_stall",  32'(if_stall),  32'd1);
        chk("t2.c2.mem_stall", 32'(mem_stall), 32'd0);
        tick(); mem_req = 1'b0; mem_write = 1'b0; mid();
        chk("t2.c3.bus_req", 32'(bus_req), 32'd0);
        tick(); bus_ready = 1'b1; bus_rdata = 32'h1122_3344;
        push_exp(1'b0, 1'b1, 32'h1122_3344, 1'b0, 2'b00); mid();
        chk("t2.c4.bus_req", 32'(bus_req),   32'd1);
        chk("t2.c4.addr",    bus_addr,       32'h400);
        chk("t2.c4.write",   32'(bus_write), 32'd0);
        chk("t2.c4.wstrb",   32'(bus_wstrb), 32'd0);
        tick(); bus_ready = 1'b0; mid();
        check_resp("t2.if");
        tick(); if_req = 1'b0; mid();

        // misaligned loads never touch the bus
        for (int k = 0; k < 3; k++) begin
            tick();
            mem_req = 1'b1; mem_write = 1'b0; mem_size = mis_size[k]; mem_addr = mis_addr[k];
            push_exp(1'b1, 1'b0, 32'h0, 1'b1, 2'b01);
            mid();
            chk($sformatf("t3.%0d.c0.bus_req", k), 32'(bus_req), 32'd0);
            tick(); mid();
            chk($sformatf("t3.%0d.c1.bus_req", k), 32'(bus_req), 32'd0);
            check_resp($sformatf("t3.%0d", k));
            tick(); mem_req = 1'b0; mid();
            chk($sformatf("t3.%0d.c2.bus_req", k), 32'(bus_req), 32'd0);
        end

        // timeout with TIMEOUT=4
        tick(); if_req = 1'b1; if_addr = 32'h600; bus_ready = 1'b0;
        push_exp(1'b0, 1'b0, 32'h0, 1'b1, 2'b10); mid();
        n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            mid();
            if (bus_req) begin
                n_busy++;
                chk("t4.addr", bus_addr, 32'h600);
            end
            if (if_done || mem_done) break;
        end
        chk("t4.busy_cycles", 32'(n_busy), 32'd4);
        wait_done("t4.timeout", 1);
        chk("t4.bus_req_after", 32'(bus_req), 32'd0);
        tick(); if_req = 1'b0; mid();
        tick(); if_req = 1'b1; if_addr = 32'h604; mid();
        tick(); bus_ready = 1'b1; bus_rdata = 32'h00A0_0093;
        push_exp(1'b0, 1'b1, 32'h00A0_0093, 1'b0, 2'b00); mid();
        chk("t4.next.bus_req", 32'(bus_req), 32'd1);
        chk("t4.next.addr",    bus_addr,     32'h604);
        tick(); bus_ready = 1'b0; mid();
        check_resp("t4.next");
        tick(); if_req = 1'b0; mid();

        // reset during a data transaction
        tick(); mem_req = 1'b1; mem_write = 1'b0; mem_size = 2'b10; mem_addr = 32'h700; mid();
        tick(); mid();
        chk("t5.c1.bus_req", 32'(bus_req), 32'd1);
        tick(); rst = 1'b1; mid();
        chk("t5.c2.bus_req", 32'(bus_req), 32'd1);
        tick(); rst = 1'b0; mid();
        check_all_zero("t5.rst");
        chk("t5.rst.mem_stall", 32'(mem_stall), 32'd1);
        tick(); bus_ready = 1'b1; bus_rdata = 32'h55AA_55AA;
        push_exp(1'b1, 1'b1, 32'h55AA_55AA, 1'b0, 2'b00); mid();
        chk("t5.reissue.bus_req", 32'(bus_req), 32'd1);
        chk("t5.reissue.addr",    bus_addr,     32'h700);
        tick(); bus_ready = 1'b0; mid();
        check_resp("t5.reissue");
        tick(); mem_req = 1'b0; mid();

        // half store, then slow word read
        tick(); mem_req = 1'b1; mem_write = 1'b1; mem_size = 2'b01; mem_addr = 32'h302; mem_wdata = 32'h0000_1234; mid();
        tick(); bus_ready = 1'b1; bus_rdata = 32'h0;
        push_exp(1'b1, 1'b1, 32'h0, 1'b0, 2'b00); mid();
        chk("t6.st.wstrb", 32'(bus_wstrb), 32'b1100);
        chk("t6.st.wdata", bus_wdata,      32'h1234_1234);
        chk("t6.st.addr",  bus_addr,       32'h300);
        chk("t6.st.write", 32'(bus_write), 32'd1);
        tick(); bus_ready = 1'b0; mid();
        check_resp("t6.st");
        tick(); mem_req = 1'b0; mem_write = 1'b0; mid();
        tick(); mem_req = 1'b1; mem_size = 2'b10; mem_addr = 32'h304; mid();
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 4) begin
                bus_ready = 1'b1;
                bus_rdata = 32'hCAFE_F00D;
                push_exp(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 2'b00);
            end
            mid();
            chk($sformatf("t6.rd.c%0d.bus_req", c),  32'(bus_req),   32'd1);
            chk($sformatf("t6.rd.c%0d.addr", c),     bus_addr,       32'h304);
            chk($sformatf("t6.rd.c%0d.wstrb", c),    32'(bus_wstrb), 32'd0);
            chk($sformatf("t6.rd.c%0d.mem_done", c), 32'(mem_done),  32'd0);
        end
        tick(); bus_ready = 1'b0; mid();
        check_resp("t6.rd.c5");
        chk("t6.rd.c5.bus_req", 32'(bus_req), 32'd0);
        tick(); mem_req = 1'b0; mid();
        chk("end.sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
